// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types and constants for the bit-serial ALU sequencer.
//   state_t  : sequencer FSM states
//   OP_*     : 3-bit op codes {M,S1,S0} understood by the 1-bit ALU slice
//   lane_of  : one-hot Fi lane that the slice drives for a given op code
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS_A    = 3'b000;
  localparam logic [2:0] OP_NOT_A     = 3'b001;
  localparam logic [2:0] OP_XOR       = 3'b010;
  localparam logic [2:0] OP_XNOR      = 3'b011;
  localparam logic [2:0] OP_PASS_A_M  = 3'b100;
  localparam logic [2:0] OP_NOT_A_M   = 3'b101;
  localparam logic [2:0] OP_OR        = 3'b110;
  localparam logic [2:0] OP_NOTA_OR_B = 3'b111;

  // The slice reports each function on its own Fi bit; the M=0/M=1
  // variants of pass-A and not-A share a lane.
  function automatic logic [5:0] lane_of(input logic [2:0] op);
    logic [5:0] lane;
    case (op)
      OP_PASS_A, OP_PASS_A_M: lane = 6'b000001;
      OP_NOT_A,  OP_NOT_A_M:  lane = 6'b000010;
      OP_XOR:                 lane = 6'b000100;
      OP_XNOR:                lane = 6'b001000;
      OP_OR:                  lane = 6'b010000;
      default:                lane = 6'b100000;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/alu_fi_reduce.sv
// alu_fi_reduce
// Combinational reduction of the slice's one-hot Fi vector to one result bit.
// Optional lane check enabled by macro ALU_LANE_CHECK_EN.
// Ports:
//   alu_f         in  [5:0] Fi from the 1-bit slice
//   r             out       OR-reduction of alu_f
//   op            in  [2:0] latched op code (lane check build only)
//   lane_mismatch out       alu_f differs from the expected lane vector
//                           (lane check build only)
module alu_fi_reduce
  import alu_seq_pkg::*;
(
  input  logic [5:0] alu_f,
  output logic       r
`ifdef ALU_LANE_CHECK_EN
  ,
  input  logic [2:0] op,
  output logic       lane_mismatch
`endif
);

  assign r = |alu_f;

`ifdef ALU_LANE_CHECK_EN
  // A healthy slice either drives only the expected lane (r=1) or nothing.
  assign lane_mismatch = (alu_f != (lane_of(op) & {6{r}}));
`endif

endmodule

// File: rtl/alu_bit_serial_seq.sv
// alu_bit_serial_seq
// Bit-serial sequencer around an external 1-bit ALU slice. Latches two W-bit
// operands and an op code, feeds the slice one bit per cycle (LSB first),
// reduces the slice's Fi back to a result bit and assembles the W-bit result.
// Optional feature macro: ALU_LANE_CHECK_EN (adds sticky lane_err output).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op, a_in, b_in  request and operands, sampled only in IDLE
//   busy                high in SHIFT and DONE
//   done                one-cycle pulse, result/zero valid
//   result, zero        assembled result and result==0 flag
//   alu_m/s1/s0         latched op to the slice
//   alu_a, alu_b        current operand bits to the slice
//   alu_f               Fi from the slice (combinational return)
//   lane_err            sticky Fi lane mismatch (ALU_LANE_CHECK_EN only)
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | W cycles, one operand bit per cycle through the slice
// DONE  | publish result/zero, pulse done on the following cycle
module alu_bit_serial_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         alu_m,
  output logic         alu_s1,
  output logic         alu_s0,
  output logic         alu_a,
  output logic         alu_b,
  input  logic [5:0]   alu_f
`ifdef ALU_LANE_CHECK_EN
  ,
  output logic         lane_err
`endif
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     res_sh;
  logic [CNT_W-1:0] cnt;
  logic             r;

  assign alu_m  = op_q[2];
  assign alu_s1 = op_q[1];
  assign alu_s0 = op_q[0];

  // Shift registers fill with zeros, so after W shifts (and after reset)
  // they are empty: the slice sees 0 on A/B everywhere outside SHIFT.
  assign alu_a = a_sh[0];
  assign alu_b = b_sh[0];

`ifdef ALU_LANE_CHECK_EN
  logic lane_mismatch;

  alu_fi_reduce u_reduce (
    .alu_f         (alu_f),
    .r             (r),
    .op            (op_q),
    .lane_mismatch (lane_mismatch)
  );
`else
  alu_fi_reduce u_reduce (
    .alu_f (alu_f),
    .r     (r)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
`ifdef ALU_LANE_CHECK_EN
      lane_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            a_sh   <= a_in;
            b_sh   <= b_in;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef ALU_LANE_CHECK_EN
            lane_err <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          res_sh <= {r, res_sh[W-1:1]};
          a_sh   <= {1'b0, a_sh[W-1:1]};
          b_sh   <= {1'b0, b_sh[W-1:1]};
`ifdef ALU_LANE_CHECK_EN
          if (lane_mismatch) lane_err <= 1'b1;
`endif
          // Terminate on compare so non-power-of-two W works.
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          result <= res_sh;
          zero   <= (res_sh == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
